// File: rtl/ucsbece154a_encoder_pkg.sv
// ucsbece154a_encoder_pkg: instruction classes, RV32I opcode/funct3 constants and the field packer
package ucsbece154a_encoder_pkg;

    typedef enum logic [2:0] {
        CL_LW  = 3'd0,
        CL_SW  = 3'd1,
        CL_R   = 3'd2,
        CL_BEQ = 3'd3,
        CL_I   = 3'd4,
        CL_JAL = 3'd5,
        CL_LUI = 3'd6,
        CL_ILL = 3'd7
    } instr_class_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    // Fields a format does not carry are filled from imm or left zero, never from an idle port.
    function automatic logic [31:0] encode(input instr_class_t cls, input logic [4:0] rd, rs1, rs2,
                                           input logic [2:0] f3, input logic f7b5, input logic [31:0] imm);
        case (cls)
            CL_LW:   encode = {imm[11:0], rs1, F3_LW, rd, OP_LW};
            CL_SW:   encode = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OP_SW};
            CL_R:    encode = {1'b0, f7b5, 5'b00000, rs2, rs1, f3, rd, OP_R};
            CL_BEQ:  encode = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OP_BEQ};
            CL_I:    encode = {imm[11:0], rs1, f3, rd, OP_I};
            CL_JAL:  encode = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            CL_LUI:  encode = {imm[31:12], rd, OP_LUI};
            default: encode = '0;
        endcase
    endfunction

endpackage

// File: rtl/ucsbece154a_encoder_fifo.sv
// ucsbece154a_encoder_fifo: 2-entry, 64-bit FIFO with a registered not-full flag
module ucsbece154a_encoder_fifo (
    input  logic        clk,
    input  logic        reset_n_i,
    input  logic        push,
    input  logic [63:0] din,
    input  logic        pop,
    output logic        not_empty,
    output logic        not_full,
    output logic [63:0] dout
);

    logic [63:0] mem [2];
    logic [1:0]  count;
    logic [1:0]  count_nx;
    logic        wr_ptr;
    logic        rd_ptr;
    logic        do_push;
    logic        do_pop;

    always_comb begin
        do_pop   = pop && count != 2'd0;
        do_push  = push && count != 2'd2;
        count_nx = count + {1'b0, do_push} - {1'b0, do_pop};
    end

    // not_full is looked ahead from count_nx so it stays a flop with no path from pop
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count    <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            not_full <= 1'b0;
        end else begin
            count    <= count_nx;
            not_full <= count_nx != 2'd2;
            if (do_push) wr_ptr <= !wr_ptr;
            if (do_pop) rd_ptr <= !rd_ptr;
        end
    end

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;

    assign not_empty = count != 2'd0;
    assign dout      = not_empty ? mem[rd_ptr] : '0;

endmodule

// File: rtl/ucsbece154a_instr_encoder.sv
// ucsbece154a_instr_encoder: packs instruction requests into RV32I words tagged with addresses.
// Define ENCODER_RANGE_CHECK_EN to reject out-of-range immediates and unsupported ALU funct3.
module ucsbece154a_instr_encoder
    import ucsbece154a_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n_i,
    input  logic        clear_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [2:0]  class_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7b5_i,
    input  logic [31:0] imm_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] addr_o,
    output logic        err_o
);

    instr_class_t cls;
    logic         legal;
    logic         accept;
    logic         push;
    logic [31:0]  addr_q;
    logic [31:0]  tag_addr;
    logic [63:0]  fifo_dout;

    assign cls = instr_class_t'(class_i);

`ifdef ENCODER_RANGE_CHECK_EN
    logic imm12_ok;
    logic beq_ok;
    logic jal_ok;
    logic f3_ok;

    // A value fits an N-bit signed field when all bits from N-1 upward agree.
    always_comb begin
        imm12_ok = &imm_i[31:11] || ~|imm_i[31:11];
        beq_ok   = (&imm_i[31:12] || ~|imm_i[31:12]) && !imm_i[0];
        jal_ok   = (&imm_i[31:20] || ~|imm_i[31:20]) && !imm_i[0];
        f3_ok    = funct3_i inside {F3_ADD, F3_SLT, F3_OR, F3_AND};
        case (cls)
            CL_LW, CL_SW: legal = imm12_ok;
            CL_I:         legal = imm12_ok && f3_ok;
            CL_R:         legal = f3_ok;
            CL_BEQ:       legal = beq_ok;
            CL_JAL:       legal = jal_ok;
            CL_LUI:       legal = ~|imm_i[11:0];
            default:      legal = 1'b0;
        endcase
    end
`else
    assign legal = cls != CL_ILL;
`endif

    assign accept   = valid_i && ready_o;
    assign push     = accept && legal;
    assign tag_addr = clear_i ? BASE_ADDR : addr_q;

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            addr_q <= BASE_ADDR;
            err_o  <= 1'b0;
        end else begin
            addr_q <= push ? tag_addr + 32'd4 : tag_addr;
            err_o  <= (err_o && !clear_i) || (accept && !legal);
        end
    end

    ucsbece154a_encoder_fifo fifo (
        .clk       (clk),
        .reset_n_i (reset_n_i),
        .push      (push),
        .din       ({encode(cls, rd_i, rs1_i, rs2_i, funct3_i, funct7b5_i, imm_i), tag_addr}),
        .pop       (ready_i),
        .not_empty (valid_o),
        .not_full  (ready_o),
        .dout      (fifo_dout)
    );

    assign instr_o = fifo_dout[63:32];
    assign addr_o  = fifo_dout[31:0];

endmodule

// File: tb/tb_ucsbece154a_instr_encoder.sv
// tb_ucsbece154a_instr_encoder: directed scenarios plus random traffic against a queue-based model
module tb_ucsbece154a_instr_encoder;

    logic        clk = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b0;
    logic [2:0]  class_i = 3'd0;
    logic [4:0]  rd_i = 5'd0;
    logic [4:0]  rs1_i = 5'd0;
    logic [4:0]  rs2_i = 5'd0;
    logic [2:0]  funct3_i = 3'd0;
    logic        funct7b5_i = 1'b0;
    logic [31:0] imm_i = 32'd0;
    logic        ready_o;
    logic        valid_o;
    logic        err_o;
    logic [31:0] instr_o;
    logic [31:0] addr_o;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [63:0] q[$];
    logic [31:0] addr_m = 32'd0;
    logic        err_m = 1'b0;
    logic        rdy_m = 1'b0;

    ucsbece154a_instr_encoder dut (
        .clk        (clk),
        .reset_n_i  (reset_n_i),
        .clear_i    (clear_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .class_i    (class_i),
        .rd_i       (rd_i),
        .rs1_i      (rs1_i),
        .rs2_i      (rs2_i),
        .funct3_i   (funct3_i),
        .funct7b5_i (funct7b5_i),
        .imm_i      (imm_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .instr_o    (instr_o),
        .addr_o     (addr_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    function automatic bit legal_m(input int cls, input int f3, input logic [31:0] imm);
        int s;
        s = imm;
        if (cls == 7) return 1'b0;
`ifdef ENCODER_RANGE_CHECK_EN
        case (cls)
            0, 1: return s >= -2048 && s <= 2047;
            2:    return f3 == 0 || f3 == 2 || f3 == 6 || f3 == 7;
            3:    return s >= -4096 && s <= 4094 && imm[0] == 1'b0;
            4:    return s >= -2048 && s <= 2047 && (f3 == 0 || f3 == 2 || f3 == 6 || f3 == 7);
            5:    return s >= -(1 << 20) && s <= (1 << 20) - 2 && imm[0] == 1'b0;
            default: return (imm % 4096) == 0;
        endcase
`else
        return f3 >= 0;
`endif
    endfunction

    function automatic logic [31:0] enc_m(input int cls, input logic [31:0] rd, rs1, rs2, f3, f7,
                                          input logic [31:0] imm);
        case (cls)
            0: return (imm & 32'hFFF) << 20 | rs1 << 15 | 32'd2 << 12 | rd << 7 | 32'h03;
            1: return ((imm >> 5) & 32'h7F) << 25 | rs2 << 20 | rs1 << 15 | 32'd2 << 12
                      | (imm & 32'h1F) << 7 | 32'h23;
            2: return f7 << 30 | rs2 << 20 | rs1 << 15 | f3 << 12 | rd << 7 | 32'h33;
            3: return ((imm >> 12) & 32'h1) << 31 | ((imm >> 5) & 32'h3F) << 25 | rs2 << 20
                      | rs1 << 15 | ((imm >> 1) & 32'hF) << 8 | ((imm >> 11) & 32'h1) << 7 | 32'h63;
            4: return (imm & 32'hFFF) << 20 | rs1 << 15 | f3 << 12 | rd << 7 | 32'h13;
            5: return ((imm >> 20) & 32'h1) << 31 | ((imm >> 1) & 32'h3FF) << 21
                      | ((imm >> 11) & 32'h1) << 20 | ((imm >> 12) & 32'hFF) << 12 | rd << 7 | 32'h6F;
            6: return (imm & 32'hFFFFF000) | rd << 7 | 32'h37;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input int cls, input int rd, input int rs1, input int rs2, input int f3,
                       input int f7, input logic [31:0] imm);
        valid_i    = 1'b1;
        class_i    = 3'(cls);
        rd_i       = 5'(rd);
        rs1_i      = 5'(rs1);
        rs2_i      = 5'(rs2);
        funct3_i   = 3'(f3);
        funct7b5_i = 1'(f7);
        imm_i      = imm;
    endtask

    // Advance one clock edge, updating the model from the pre-edge inputs, then check outputs.
    task automatic tick();
        bit          acc;
        bit          lg;
        logic [31:0] tag;
        if (!reset_n_i) begin
            q.delete();
            addr_m = 32'd0;
            err_m  = 1'b0;
        end else begin
            acc = valid_i && rdy_m;
            lg  = legal_m(int'(class_i), int'(funct3_i), imm_i);
            if (ready_i && q.size() > 0) void'(q.pop_front());
            tag = clear_i ? 32'd0 : addr_m;
            if (acc && lg) q.push_back({enc_m(int'(class_i), 32'(rd_i), 32'(rs1_i), 32'(rs2_i),
                                              32'(funct3_i), 32'(funct7b5_i), imm_i), tag});
            addr_m = (acc && lg) ? tag + 32'd4 : tag;
            err_m  = (err_m && !clear_i) || (acc && !lg);
        end
        @(posedge clk);
        #1;
        rdy_m = reset_n_i && q.size() < 2;
        chk("valid_o", 32'(valid_o), 32'(q.size() != 0));
        chk("ready_o", 32'(ready_o), 32'(rdy_m));
        chk("err_o", 32'(err_o), 32'(err_m));
        if (q.size() != 0) begin
            chk("instr_o", instr_o, q[0][63:32]);
            chk("addr_o", addr_o, q[0][31:0]);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_addr", addr_o, 32'd0);
        reset_n_i = 1'b1;
        #1;
        chk("rel_ready_low", 32'(ready_o), 32'd0);
        tick();
        chk("rel_ready_high", 32'(ready_o), 32'd1);

        // a) addi x1,x0,5 with junk on rs2/funct7b5 that must be ignored
        ready_i = 1'b1;
        clear_i = 1'b1;
        req(4, 1, 0, 31, 0, 1, 32'd5);
        tick();
        valid_i = 1'b0;
        clear_i = 1'b0;
        chk("a_instr", instr_o, 32'h00500093);
        chk("a_addr", addr_o, 32'h0);
        tick();

        // b) sub x3,x1,x2 then lui x5 (unused rs1/rs2/funct ports driven)
        clear_i = 1'b1;
        req(2, 3, 1, 2, 0, 1, 32'd0);
        tick();
        clear_i = 1'b0;
        chk("b_sub", instr_o, 32'h402081B3);
        chk("b_sub_addr", addr_o, 32'h0);
        req(6, 5, 9, 7, 3, 1, 32'h12345000);
        tick();
        valid_i = 1'b0;
        chk("b_lui", instr_o, 32'h123452B7);
        chk("b_lui_addr", addr_o, 32'h4);
        tick();

        // c) beq x1,x2,-4 then jal x1,8
        clear_i = 1'b1;
        req(3, 9, 1, 2, 5, 1, 32'hFFFFFFFC);
        tick();
        clear_i = 1'b0;
        chk("c_beq", instr_o, 32'hFE208EE3);
        req(5, 1, 4, 6, 0, 0, 32'd8);
        tick();
        valid_i = 1'b0;
        chk("c_jal", instr_o, 32'h008000EF);
        tick();

        // d) back-pressure: fill, stall the third request, then drain
        ready_i = 1'b0;
        clear_i = 1'b1;
        req(4, 1, 0, 0, 0, 0, 32'd1);
        tick();
        clear_i = 1'b0;
        chk("d_ready_after1", 32'(ready_o), 32'd1);
        req(4, 2, 0, 0, 0, 0, 32'd2);
        tick();
        chk("d_ready_after2", 32'(ready_o), 32'd0);
        req(4, 3, 0, 0, 0, 0, 32'd3);
        tick();
        chk("d_stall_ready", 32'(ready_o), 32'd0);
        chk("d_first_addr", addr_o, 32'h0);
        ready_i = 1'b1;
        tick();
        chk("d_second_addr", addr_o, 32'h4);
        tick();
        valid_i = 1'b0;
        chk("d_third_addr", addr_o, 32'h8);
        chk("d_third_instr", instr_o, 32'h00300193);
        tick();
        chk("d_drained", 32'(valid_o), 32'd0);

        // e) illegal requests set the sticky flag without consuming an address
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
`ifdef ENCODER_RANGE_CHECK_EN
        req(3, 0, 1, 2, 0, 0, 32'd3);
        tick();
        valid_i = 1'b0;
        chk("e_beq_err", 32'(err_o), 32'd1);
        chk("e_beq_empty", 32'(valid_o), 32'd0);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
`endif
        req(7, 1, 2, 3, 0, 0, 32'd0);
        tick();
        valid_i = 1'b0;
        chk("e_ill_err", 32'(err_o), 32'd1);
        chk("e_ill_empty", 32'(valid_o), 32'd0);
        req(4, 1, 0, 0, 0, 0, 32'd5);
        tick();
        valid_i = 1'b0;
        chk("e_addi_addr", addr_o, 32'h0);
        chk("e_err_holds", 32'(err_o), 32'd1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("e_err_cleared", 32'(err_o), 32'd0);

        // f) asynchronous reset with two words buffered
        ready_i = 1'b0;
        req(4, 1, 0, 0, 0, 0, 32'd7);
        tick();
        req(4, 2, 0, 0, 0, 0, 32'd8);
        tick();
        valid_i = 1'b0;
        #2;
        reset_n_i = 1'b0;
        q.delete();
        addr_m = 32'd0;
        err_m  = 1'b0;
        rdy_m  = 1'b0;
        #1;
        chk("f_valid_now", 32'(valid_o), 32'd0);
        chk("f_ready_now", 32'(ready_o), 32'd0);
        chk("f_instr_now", instr_o, 32'd0);
        chk("f_addr_now", addr_o, 32'd0);
        tick();
        reset_n_i = 1'b1;
        ready_i = 1'b1;
        tick();
        req(1, 4, 5, 6, 0, 0, 32'd12);
        tick();
        valid_i = 1'b0;
        chk("f_first_addr", addr_o, 32'h0);
        tick();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] imm;
            case ($urandom_range(0, 3))
                0:       imm = $urandom;
                1:       imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                2:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                default: imm = $urandom & 32'hFFFFF000;
            endcase
            req(int'($urandom_range(0, 7)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                int'($urandom_range(0, 31)), int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), imm);
            valid_i = $urandom_range(0, 2) != 0;
            ready_i = $urandom_range(0, 2) != 0;
            clear_i = $urandom_range(0, 19) == 0;
            tick();
        end
        valid_i = 1'b0;
        clear_i = 1'b0;
        ready_i = 1'b1;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ucsbece154a_instr_encoder.md
UCSBECE154A_INSTR_ENCODER -- requirements
Module: ucsbece154a_instr_encoder

Interface
REQ-001 Parameters SHALL be:
- BASE_ADDR, 32'h0000_0000, word address assigned to the first encoded instruction.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- clear_i  in  1  synchronous clear of err_o and the address counter.
- valid_i  in  1  request valid.
- ready_o  out  1  request accepted when valid_i&ready_o.
- class_i  in  3  0 lw, 1 sw, 2 R-type, 3 beq, 4 I-type ALU, 5 jal, 6 lui, 7 illegal.
- rd_i, rs1_i, rs2_i  in  5 each  register indices.
- funct3_i  in  3  ALU function for R/I.
- funct7b5_i  in  1  subtract select, R-type only.
- imm_i  in  32  signed byte offset or immediate (lui: full upper value).
- valid_o  out  1  instr_o/addr_o valid.
- ready_i  in  1  consumer accepts when valid_o&ready_i.
- instr_o  out  32  encoded RV32I word.
- addr_o  out  32  instruction-memory address of instr_o.
- err_o  out  1  sticky illegal-request flag.
REQ-003 Clock is clk, one domain; reset_n_i SHALL be asynchronous assert, active-low.

Function
REQ-004 Encoding SHALL match the datapath decoder:
- lw: op 0000011, f3 010, I-imm.
- sw: op 0100011, f3 010, S-imm.
- R: op 0110011, funct7 = {0, funct7b5_i, 00000}.
- beq: op 1100011, f3 000, B-imm.
- I-ALU: op 0010011, funct7b5_i ignored.
- jal: op 1101111, J-imm.
- lui: op 0110111, imm_i[31:12].
REQ-005 Unused fields (rs2 for I/U/J, rd for S/B, etc.) SHALL be encoded from imm or zero, never from the unused port.
REQ-006 Encoded words SHALL be buffered in a 2-entry FIFO.
- ready_o = !full, registered, with no combinational path from ready_i.
REQ-007 Latency SHALL be one cycle from acceptance to visibility on instr_o when the FIFO is empty.
REQ-008 Simultaneous push and pop SHALL leave the occupancy unchanged.
- Pop while empty is ignored.
- Order is strictly FIFO.
REQ-009 The address counter SHALL work as follows:
- Starts at BASE_ADDR.
- Each accepted legal request is tagged with the counter value, then the counter increments by 4.
- Wraps modulo 2^32.
REQ-010 An illegal request SHALL be consumed, not enqueued, and SHALL not advance the counter.
- It sets err_o on the next edge.
- err_o holds until clear_i or reset.
REQ-011 clear_i SHALL clear err_o and reload the counter to BASE_ADDR.
- FIFO contents are untouched.
- A request accepted in the same cycle as clear_i uses BASE_ADDR.
REQ-012 class_i = 7 SHALL always be illegal.

Reset
REQ-013 While reset_n_i = 0, the block SHALL hold:
- FIFO empty, valid_o=0, ready_o=0.
- err_o=0, counter=BASE_ADDR.
- instr_o=0, addr_o=0.
REQ-014 On release, ready_o SHALL rise on the first clk edge.
- Reset mid-transfer SHALL discard buffered words without emitting partial data.

Configuration
REQ-015 With ENCODER_RANGE_CHECK_EN defined, the following SHALL also be illegal:
- lw/sw/I-ALU imm outside [-2048, 2047].
- beq imm outside [-4096, 4094] or odd.
- jal imm outside [-2^20, 2^20-2] or odd.
- lui imm_i[11:0] != 0.
- R/I funct3 not in {000, 010, 110, 111}.
REQ-016 Without ENCODER_RANGE_CHECK_EN, immediates SHALL be silently truncated to field width and funct3 passed through; only class 7 is illegal.

Structure
REQ-017 Shared package ucsbece154a_encoder_pkg SHALL hold:
- the class enum typedef;
- opcode and funct3 constants, identical to the decoder's.
REQ-018 The FIFO SHALL be sub-module ucsbece154a_encoder_fifo, with depth 2 and width 64 (instr, addr).

Verification
REQ-019 Each bench scenario SHALL produce the stated response (a-f):
- a) addi x1,x0,5 (class 4, f3 000, imm 5), ready_i=1: next cycle instr_o=0x00500093, addr_o=0x0.
- b) sub x3,x1,x2 then lui x5 imm 0x12345000:
  - instr_o=0x402081B3 at addr 0x0;
  - instr_o=0x123452B7 at addr 0x4.
- c) beq x1,x2 imm -4, then jal x1 imm 8: instr_o=0xFE208EE3, then 0x008000EF.
- d) ready_i=0, three back-to-back requests:
  - ready_o falls after two acceptances;
  - raising ready_i drains in order, addresses 0x0, 0x4, then the third gets 0x8.
- e) With macro: beq imm 3, then valid addi:
  - err_o=1, nothing enqueued;
  - the addi gets addr 0x0.
  - clear_i drops err_o.
- f) reset_n_i low with 2 words buffered:
  - valid_o=0 immediately;
  - after release, the first new word has addr BASE_ADDR.
